router_in_port_buffer: RTL and testbench

- Per-port input FIFO for a mesh router, placed between the upstream link and the switch controller.
- Accepts flits from the neighbouring router's output link and applies backpressure to it via a full indication.
- Presents the head flit's destination address and a valid bit to the route-computation/arbitration logic, and pops the head when the switch grants this port.
- Supplies the controller's packet_addr/packet_valid inputs and the upstream sender's buffer_full input.

---
 rtl/router_in_port_buffer.sv | 105 ++++++++++
 tb/tb_router_in_port_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/router_in_port_buffer.sv
// router_in_port_buffer
// Per-port input FIFO for a mesh router. Flits arrive from the upstream link,
// are held in a small circular buffer, and the head flit's destination address
// is presented to route computation / arbitration. A switch grant pops the head.
//
// Handshake: upstream may push (flit_valid_i) only while buffer_full_o is low;
// a push while full is dropped and recorded in the sticky overflow_o. The switch
// may pop (pop_i) only while packet_valid_o is high; a pop while empty is ignored
// and recorded in the sticky underflow_o. All outputs are driven from registered
// state only, so a pushed flit becomes visible at the head after the push edge.
module router_in_port_buffer #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              buffer_full_o,
    output logic [7:0]        packet_addr_o,
    output logic              packet_valid_o,
    output logic [DATA_W-1:0] flit_o,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Status and accepted-transfer qualification, from registered count only
    always_comb begin
        w_full  = (r_count == CNT_W'(DEPTH));
        w_valid = (r_count != '0);
        w_push  = flit_valid_i & ~w_full;
        w_pop   = pop_i & w_valid;
    end

    // Storage write; the array is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= flit_i;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: +1 push only, -1 pop only, unchanged on both or neither
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky protocol-violation flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flit_valid_i && w_full) r_overflow  <= 1'b1;
            if (pop_i && !w_valid)      r_underflow <= 1'b1;
        end
    end

    // Head presentation; zero when empty so stale storage never leaks out
    always_comb begin
        flit_o         = w_valid ? r_mem[r_rd_ptr] : '0;
        packet_addr_o  = flit_o[7:0];
        packet_valid_o = w_valid;
        buffer_full_o  = w_full;
        count_o        = r_count;
        overflow_o     = r_overflow;
        underflow_o    = r_underflow;
    end

endmodule

// File: tb/tb_router_in_port_buffer.sv
// tb_router_in_port_buffer
// Directed bench for the router input-port FIFO: a vector table for fill/drain,
// overflow and underflow, plus hand sequences for streaming wrap and async reset.
module tb_router_in_port_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int NVEC   = 18;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              buffer_full_o;
  logic [7:0]        packet_addr_o;
  logic              packet_valid_o;
  logic [DATA_W-1:0] flit_o;
  logic              pop_i;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              underflow_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fv;
    logic [15:0] fl;
    logic        pop;
    logic [2:0]  cnt;
    logic        full;
    logic        vld;
    logic [7:0]  addr;
    logic [15:0] flit;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs [NVEC];
  logic [DATA_W-1:0] exp_q [$];

  router_in_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .flit_i         (flit_i),
    .flit_valid_i   (flit_valid_i),
    .buffer_full_o  (buffer_full_o),
    .packet_addr_o  (packet_addr_o),
    .packet_valid_o (packet_valid_o),
    .flit_o         (flit_o),
    .pop_i          (pop_i),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drive inputs on the falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic fv, input logic [15:0] fl, input logic pop);
    @(negedge clk);
    flit_valid_i = fv;
    flit_i       = fl;
    pop_i        = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " count"}, 32'(count_o), 32'(v.cnt));
    chk({tag, " full"},  32'(buffer_full_o), 32'(v.full));
    chk({tag, " valid"}, 32'(packet_valid_o), 32'(v.vld));
    chk({tag, " addr"},  32'(packet_addr_o), 32'(v.addr));
    chk({tag, " flit"},  32'(flit_o), 32'(v.flit));
    chk({tag, " ovf"},   32'(overflow_o), 32'(v.ovf));
    chk({tag, " unf"},   32'(underflow_o), 32'(v.unf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flit_valid_i = 1'b0;
    pop_i = 1'b0;
    flit_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t idle_v;
    rst_n = 1'b0;
    flit_valid_i = 1'b0;
    flit_i = '0;
    pop_i = 1'b0;

    //            fv   flit      pop  cnt  full vld  addr   flit      ovf  unf
    vecs[0]  = '{1'b1, 16'hA111, 1'b0, 3'd1, 1'b0, 1'b1, 8'h11, 16'hA111, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hB222, 1'b0, 3'd2, 1'b0, 1'b1, 8'h11, 16'hA111, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'hC333, 1'b0, 3'd3, 1'b0, 1'b1, 8'h11, 16'hA111, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'hD444, 1'b0, 3'd4, 1'b1, 1'b1, 8'h11, 16'hA111, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b1, 8'h22, 16'hB222, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 8'h33, 16'hC333, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b1, 8'h44, 16'hD444, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0101, 1'b0, 3'd1, 1'b0, 1'b1, 8'h01, 16'h0101, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h0202, 1'b0, 3'd2, 1'b0, 1'b1, 8'h01, 16'h0101, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0303, 1'b0, 3'd3, 1'b0, 1'b1, 8'h01, 16'h0101, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h0404, 1'b0, 3'd4, 1'b1, 1'b1, 8'h01, 16'h0101, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'hEEEE, 1'b1, 3'd3, 1'b0, 1'b1, 8'h02, 16'h0202, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 8'h03, 16'h0303, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b1, 8'h04, 16'h0404, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 16'h0F57, 1'b1, 3'd1, 1'b0, 1'b1, 8'h57, 16'h0F57, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    // last pop of an empty-after-pop FIFO is legal, but underflow stays sticky
    vecs[17].unf = 1'b1;

    idle_v = '{1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};

    // reset then idle
    do_reset();
    #1;
    chk_all("reset", idle_v);
    step(1'b0, 16'h0, 1'b0);
    chk_all("idle", idle_v);

    // table: fill/drain, overflow, underflow
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].fv, vecs[i].fl, vecs[i].pop);
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // streaming with wrap: count held at 2 across 10 push+pop cycles
    do_reset();
    #1;
    chk("strm reset ovf", 32'(overflow_o), 32'd0);
    chk("strm reset unf", 32'(underflow_o), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'h1000 + 16'(i), 1'b0);
      exp_q.push_back(16'h1000 + 16'(i));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h1002 + 16'(i), 1'b1);
      exp_q.push_back(16'h1002 + 16'(i));
      void'(exp_q.pop_front());
      chk($sformatf("strm%0d count", i), 32'(count_o), 32'(exp_q.size()));
      chk($sformatf("strm%0d flit", i), 32'(flit_o), 32'(exp_q[0]));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h0, 1'b1);
      void'(exp_q.pop_front());
      chk($sformatf("strm drain%0d count", i), 32'(count_o), 32'(exp_q.size()));
      chk($sformatf("strm drain%0d flit", i), 32'(flit_o),
          (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    end
    chk("strm ovf", 32'(overflow_o), 32'd0);
    chk("strm unf", 32'(underflow_o), 32'd0);

    // asynchronous reset mid-operation with 3 flits stored
    step(1'b1, 16'h5501, 1'b0);
    step(1'b1, 16'h5502, 1'b0);
    step(1'b1, 16'h5503, 1'b0);
    flit_valid_i = 1'b0;
    chk("pre-arst count", 32'(count_o), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst count", 32'(count_o), 32'd0);
    chk("arst valid", 32'(packet_valid_o), 32'd0);
    chk("arst flit", 32'(flit_o), 32'd0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 1'b0);
    chk("post-arst count", 32'(count_o), 32'd1);
    chk("post-arst addr", 32'(packet_addr_o), 32'h34);
    chk("post-arst flit", 32'(flit_o), 32'h1234);
    step(1'b0, 16'h0, 1'b1);
    chk("post-arst empty", 32'(packet_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
